// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch controller.
//   XLEN       : address/PC width
//   INSTR_W    : instruction word width
//   PC_STEP    : byte increment between sequential instructions
//   ALIGN_MASK : clears the byte-offset bits of a redirect target
//   fetch_state_e : fetch FSM state encoding
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StValid
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen -- program counter register and next-PC selection.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-high reset, loads RESET_VEC
//   load      in   load the (word-aligned) load_addr; wins over advance
//   load_addr in   redirect target, low two bits dropped here
//   advance   in   step to the next sequential instruction, wrapping to
//                  RESET_VEC once pc+PC_STEP reaches PROG_LIMIT
//   pc        out  current program counter
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned     PROG_LIMIT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_addr,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_next;

    always_comb begin
        // Plain 32-bit add: a PC near 2^32 wraps modulo 2^32 before the bound test.
        pc_seq  = pc + PC_STEP;
        pc_next = pc;
        if (load) begin
            pc_next = load_addr & ALIGN_MASK;
        end else if (advance) begin
            pc_next = (pc_seq >= XLEN'(PROG_LIMIT)) ? RESET_VEC : pc_seq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- single-outstanding instruction fetch controller.
// Issues one imem request at a time, holds the returned word for downstream
// until accepted, and handles redirects (including flushing an in-flight fetch).
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   stall                 blocks issue of new fetches
//   redirect_valid/addr   one-cycle redirect pulse and target
//   imem_req/addr         one-cycle request strobe and address (registered)
//   imem_ack/rdata        response strobe and instruction word
//   instr_valid/instr/instr_pc  instruction presented downstream
//   instr_ready           downstream accept
//   fetch_count           completed-transfer count
// Build option: define FETCH_PERF_CNT_EN to enable fetch_count; otherwise it is 0.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
    parameter int unsigned     PROG_LIMIT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_addr,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc,
    input  logic               instr_ready,
    output logic [XLEN-1:0]    fetch_count
);

    fetch_state_e    state_q;
    logic            flush_q;
    logic [XLEN-1:0] pc;
    logic            pc_advance;

    // A redirect arriving with the ack discards that response, so no advance.
    assign pc_advance = (state_q == StWait) && imem_ack && !flush_q && !redirect_valid;

    fetch_pc_gen #(
        .RESET_VEC  (RESET_VEC),
        .PROG_LIMIT (PROG_LIMIT)
    ) u_pc_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (redirect_valid),
        .load_addr (redirect_addr),
        .advance   (pc_advance),
        .pc        (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            flush_q     <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_VEC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            imem_req <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!stall) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    // Request goes out with the pre-redirect PC; mark it for discard.
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                    state_q   <= StWait;
                    if (redirect_valid) begin
                        flush_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (imem_ack) begin
                        if (flush_q || redirect_valid) begin
                            flush_q <= 1'b0;
                            state_q <= stall ? StIdle : StIssue;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state_q     <= StValid;
                        end
                    end else if (redirect_valid) begin
                        flush_q <= 1'b1;
                    end
                end
                StValid: begin
                    // Redirect squashes a same-cycle transfer; both leave VALID.
                    if (redirect_valid || instr_ready) begin
                        instr_valid <= 1'b0;
                        state_q     <= stall ? StIdle : StIssue;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if ((state_q == StValid) && instr_ready && !redirect_valid) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule
